// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST sequencer.
// The truth tables are indexed by {b,a}.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;

  localparam logic [3:0] AND_TT = 4'b1000;
  localparam logic [3:0] OR_TT  = 4'b1110;
  localparam logic [3:0] XOR_TT = 4'b0110;

endpackage

// File: rtl/gate_bist_sequencer.sv
// Sweeps a two-input gate through all input combinations, lets each vector
// settle, then checks the gate output against a truth table and logs failures.
module gate_bist_sequencer
  import gate_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ITERATIONS    = 1,
  parameter logic [3:0] TRUTH_TABLE   = AND_TT,
  parameter int         CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] ITER_LAST   = 4'(ITERATIONS - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       iter_q, iter_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [1:0]       fvec_q, fvec_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic last_sample;
  logic mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign last_sample = (vec_q == LAST_VEC) && (iter_q == ITER_LAST);
  assign mismatch    = (gate_y != TRUTH_TABLE[vec_q]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      iter_q   <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fvec_q   <= '0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      iter_q   <= iter_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fvec_q   <= fvec_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = APPLY;
      APPLY: begin
        if (abort)               state_d = IDLE;
        else if (settle_q == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort)            state_d = IDLE;
        else if (last_sample) state_d = DONE;
        else                  state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    vec_d    = vec_q;
    iter_d   = iter_q;
    settle_d = settle_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d    = '0;
          iter_d   = '0;
          settle_d = SETTLE_LOAD;
          err_d    = '0;
          fv_d     = 1'b0;
          fvec_d   = '0;
        end
      end
      APPLY: begin
        if (!abort && settle_q != '0) settle_d = settle_q - 4'd1;
      end
      SAMPLE: begin
        // The compare is recorded even when abort arrives in this cycle.
        if (mismatch) begin
          err_d = sat_inc(err_q);
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (!abort && !last_sample) begin
          vec_d    = vec_q + 2'd1;
          settle_d = SETTLE_LOAD;
          if (vec_q == LAST_VEC) iter_d = iter_q + 4'd1;
        end
      end
      default: ;
    endcase

    busy_d   = (state_d == APPLY) || (state_d == SAMPLE);
    done_d   = (state_d == DONE);
    pass_d   = done_d && (err_d == '0);
    gate_a_d = busy_d & vec_d[0];
    gate_b_d = busy_d & vec_d[1];
  end

  assign gate_a     = gate_a_q;
  assign gate_b     = gate_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Directed bench: a behavioural gate (good AND, stuck-at-0, stuck-at-1) sits
// behind each sequencer; expected values are worked out by hand from the timing.
module tb_gate_bist_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       start6 = 1'b0, abort6 = 1'b0;
  int         mode = 0;  // 0 = AND, 1 = stuck-at-0, 2 = stuck-at-1

  logic       gate_y, gate_a, gate_b, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [1:0] fail_vec;

  logic       gate_y6, gate_a6, gate_b6, busy6, done6, pass6, fail_valid6;
  logic [3:0] err_count6;
  logic [1:0] fail_vec6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign gate_y  = (mode == 0) ? (gate_a & gate_b) : (mode == 2);
  assign gate_y6 = 1'b1;

  gate_bist_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_y(gate_y),
    .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  gate_bist_sequencer #(.ITERATIONS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6), .gate_y(gate_y6),
    .gate_a(gate_a6), .gate_b(gate_b6), .busy(busy6), .done(done6), .pass(pass6),
    .err_count(err_count6), .fail_valid(fail_valid6), .fail_vec(fail_vec6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold start for one cycle t; returns inside cycle t+1.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".ab"}, {gate_b, gate_a}, 0);
  endtask

  initial begin
    logic [1:0] v;

    tick(2);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.err", err_count, 0);
    chk("rst.fv", fail_valid, 0);
    chk("rst.fvec", fail_vec, 0);
    chk("rst.ab", {gate_b, gate_a}, 0);
    chk("rst6.busy", busy6, 0);
    rst_n = 1'b1;
    tick();

    // Good AND gate, default parameters
    mode = 0;
    start_run();
    for (int k = 1; k <= 12; k++) begin
      v = 2'((k - 1) / 3);
      chk($sformatf("and.busy%0d", k), busy, 1);
      chk($sformatf("and.a%0d", k), gate_a, v[0]);
      chk($sformatf("and.b%0d", k), gate_b, v[1]);
      chk($sformatf("and.done%0d", k), done, 0);
      tick();
    end
    chk("and.done", done, 1);
    chk("and.pass", pass, 1);
    chk("and.busy_end", busy, 0);
    chk("and.err", err_count, 0);
    chk("and.fv", fail_valid, 0);
    chk("and.ab_end", {gate_b, gate_a}, 0);

    // Abort in DONE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("doneabort.done", done, 1);
    chk("doneabort.pass", pass, 1);

    // Stuck-at-0: only vector 11 should fail
    mode = 1;
    start_run();
    chk("s0.done_cleared", done, 0);
    tick(12);
    chk("s0.done", done, 1);
    chk("s0.pass", pass, 0);
    chk("s0.err", err_count, 1);
    chk("s0.fv", fail_valid, 1);
    chk("s0.fvec", fail_vec, 2'b11);

    // Stuck-at-1, six sweeps: 18 mismatches saturate at 15
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    tick(71);
    chk("s1.done72", done6, 0);
    chk("s1.busy72", busy6, 1);
    tick();
    chk("s1.done73", done6, 1);
    chk("s1.pass", pass6, 0);
    chk("s1.err", err_count6, 15);
    chk("s1.fv", fail_valid6, 1);
    chk("s1.fvec", fail_vec6, 2'b00);

    // Abort at t+5 after vector 00 failed on a stuck-at-1 gate
    mode = 2;
    start_run();
    chk("ab5.err_cleared", err_count, 0);
    chk("ab5.fv_cleared", fail_valid, 0);
    tick(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("ab5");
    chk("ab5.err", err_count, 1);
    chk("ab5.fv", fail_valid, 1);
    chk("ab5.fvec", fail_vec, 2'b00);
    tick(2);
    chk("ab5.stay_idle", busy, 0);

    // Abort coinciding with the vector-01 SAMPLE still records it
    start_run();
    tick(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("ab6");
    chk("ab6.err", err_count, 2);
    chk("ab6.fvec", fail_vec, 2'b00);

    // Clean sweep after an abort
    mode = 0;
    start_run();
    chk("clean.err0", err_count, 0);
    chk("clean.fv0", fail_valid, 0);
    tick(12);
    chk("clean.done", done, 1);
    chk("clean.pass", pass, 1);
    chk("clean.err", err_count, 0);

    // Start while busy is ignored
    start_run();
    tick(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(7);
    chk("busystart.done12", done, 0);
    chk("busystart.ab12", {gate_b, gate_a}, 2'b11);
    tick();
    chk("busystart.done13", done, 1);
    chk("busystart.pass", pass, 1);

    // Start and abort together: abort wins
    start_run();
    tick(6);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("sa");
    tick();
    chk("sa.still_idle", busy, 0);

    // Synchronous reset mid-run with start held
    mode = 2;
    start_run();
    tick(7);
    chk("rr.err_before", err_count, 2);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk_idle("rr");
    chk("rr.err", err_count, 0);
    chk("rr.fv", fail_valid, 0);
    chk("rr.fvec", fail_vec, 0);
    rst_n = 1'b1;
    start = 1'b0;
    tick(3);
    chk("rr.no_run", busy, 0);
    start_run();
    chk("rr.run_after", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
